reg_file_flags: RTL and testbench

//   Architectural register file plus status-flag register. Sits directly

---
 rtl/reg_file_flags_if.sv | 36 +++
 rtl/reg_file_flags.sv | 76 +++++++
 tb/tb_reg_file_flags.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_flags_if.sv
// Bus bundle between the ALU-side controller and the register file / flag register.
// The controller drives addresses, write data and flag inputs; the register file returns read data and flags.
interface reg_file_flags_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic [AW-1:0] rd_addrA;
  logic [AW-1:0] rd_addrB;
  logic [DW-1:0] datA_out;
  logic [DW-1:0] datB_out;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] dat_in;
  logic          flag_we;
  logic          flag_clr;
  logic          sc_in;
  logic          ngtv_in;
  logic          zero_in;
  logic          sc_out;
  logic          ngtv_out;
  logic          zero_out;
  logic [DW-1:0] r0_out;
  logic [DW-1:0] r1_out;

  modport master (
    output rd_addrA, rd_addrB, wr_en, wr_addr, dat_in,
           flag_we, flag_clr, sc_in, ngtv_in, zero_in,
    input  datA_out, datB_out, sc_out, ngtv_out, zero_out, r0_out, r1_out
  );

  modport slave (
    input  rd_addrA, rd_addrB, wr_en, wr_addr, dat_in,
           flag_we, flag_clr, sc_in, ngtv_in, zero_in,
    output datA_out, datB_out, sc_out, ngtv_out, zero_out, r0_out, r1_out
  );
endinterface

// File: rtl/reg_file_flags.sv
// Architectural register file (2 read, 1 write) with optional write-to-read forwarding,
// plus the sc/ngtv/zero flag register that feeds the carry back into the ALU.
module reg_file_flags #(
  parameter int DW     = 8,
  parameter int AW     = 3,
  parameter int BYPASS = 1
) (
  input logic            clk,
  input logic            reset,
  reg_file_flags_if.slave bus
);
  localparam int NREG = 1 << AW;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic          sc_q, sc_d;
  logic          ngtv_q, ngtv_d;
  logic          zero_q, zero_d;
  logic [DW-1:0] rd_a_data;
  logic [DW-1:0] rd_b_data;

  always_comb begin
    regs_d = regs_q;
    if (bus.wr_en) regs_d[bus.wr_addr] = bus.dat_in;
  end

  // Clear beats capture; with neither, the carry is held for multi-word shifts.
  always_comb begin
    sc_d   = sc_q;
    ngtv_d = ngtv_q;
    zero_d = zero_q;
    if (bus.flag_clr) begin
      sc_d   = 1'b0;
      ngtv_d = 1'b0;
      zero_d = 1'b0;
    end else if (bus.flag_we) begin
      sc_d   = bus.sc_in;
      ngtv_d = bus.ngtv_in;
      zero_d = bus.zero_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      sc_q   <= 1'b0;
      ngtv_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      sc_q   <= sc_d;
      ngtv_q <= ngtv_d;
      zero_q <= zero_d;
    end
  end

  // Reads are forced to zero while reset is held so a pending write cannot leak through the bypass.
  always_comb begin
    rd_a_data = regs_q[bus.rd_addrA];
    rd_b_data = regs_q[bus.rd_addrB];
    if (BYPASS != 0 && bus.wr_en && bus.wr_addr == bus.rd_addrA) rd_a_data = bus.dat_in;
    if (BYPASS != 0 && bus.wr_en && bus.wr_addr == bus.rd_addrB) rd_b_data = bus.dat_in;
    if (reset) begin
      rd_a_data = '0;
      rd_b_data = '0;
    end
  end

  assign bus.datA_out = rd_a_data;
  assign bus.datB_out = rd_b_data;
  assign bus.r0_out   = regs_q[0];
  assign bus.r1_out   = regs_q[1];
  assign bus.sc_out   = sc_q;
  assign bus.ngtv_out = ngtv_q;
  assign bus.zero_out = zero_q;
endmodule

// File: tb/tb_reg_file_flags.sv
// Bench for reg_file_flags: a forwarding (BYPASS=1) and a non-forwarding (BYPASS=0) instance
// share one stimulus stream and are checked against an array-based model.
module tb_reg_file_flags;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rd_a, rd_b, wr_addr;
  logic [7:0] dat_in;
  logic       wr_en, flag_we, flag_clr, sc_i, ng_i, z_i;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [8];
  logic       msc, mng, mz;

  always #5 clk = ~clk;

  reg_file_flags_if #(.DW(8), .AW(3)) bi1 ();
  reg_file_flags_if #(.DW(8), .AW(3)) bi0 ();

  reg_file_flags #(.DW(8), .AW(3), .BYPASS(1)) u_byp   (.clk(clk), .reset(reset), .bus(bi1));
  reg_file_flags #(.DW(8), .AW(3), .BYPASS(0)) u_nobyp (.clk(clk), .reset(reset), .bus(bi0));

  assign bi1.rd_addrA = rd_a;    assign bi0.rd_addrA = rd_a;
  assign bi1.rd_addrB = rd_b;    assign bi0.rd_addrB = rd_b;
  assign bi1.wr_en    = wr_en;   assign bi0.wr_en    = wr_en;
  assign bi1.wr_addr  = wr_addr; assign bi0.wr_addr  = wr_addr;
  assign bi1.dat_in   = dat_in;  assign bi0.dat_in   = dat_in;
  assign bi1.flag_we  = flag_we; assign bi0.flag_we  = flag_we;
  assign bi1.flag_clr = flag_clr; assign bi0.flag_clr = flag_clr;
  assign bi1.sc_in    = sc_i;    assign bi0.sc_in    = sc_i;
  assign bi1.ngtv_in  = ng_i;    assign bi0.ngtv_in  = ng_i;
  assign bi1.zero_in  = z_i;     assign bi0.zero_in  = z_i;

  // Model read: reset forces zero, forwarding only on the BYPASS=1 instance.
  function automatic logic [7:0] exp_rd(input logic [2:0] a, input bit byp);
    if (reset) return 8'h00;
    if (byp && wr_en && wr_addr == a) return dat_in;
    return mem[a];
  endfunction

  function automatic logic [69:0] expv();
    return {exp_rd(rd_a, 1'b1), exp_rd(rd_b, 1'b1), exp_rd(rd_a, 1'b0), exp_rd(rd_b, 1'b0),
            mem[0], mem[1], mem[0], mem[1], msc, mng, mz, msc, mng, mz};
  endfunction

  function automatic logic [69:0] obsv();
    return {bi1.datA_out, bi1.datB_out, bi0.datA_out, bi0.datB_out,
            bi1.r0_out, bi1.r1_out, bi0.r0_out, bi0.r1_out,
            bi1.sc_out, bi1.ngtv_out, bi1.zero_out, bi0.sc_out, bi0.ngtv_out, bi0.zero_out};
  endfunction

  task automatic idle();
    reset = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; dat_in = 8'h00;
    flag_we = 1'b0; flag_clr = 1'b0; sc_i = 1'b0; ng_i = 1'b0; z_i = 1'b0;
  endtask

  // One clock: the model applies the same edge the DUTs see, then we return at the negedge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      msc = 1'b0; mng = 1'b0; mz = 1'b0;
    end else begin
      if (wr_en) mem[wr_addr] = dat_in;
      if (flag_clr) begin
        msc = 1'b0; mng = 1'b0; mz = 1'b0;
      end else if (flag_we) begin
        msc = sc_i; mng = ng_i; mz = z_i;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); rd_a = 3'd0; rd_b = 3'd0;
    reset = 1'b1;
    tick();
    // Reset still held with a matching write pending: reads must stay zero.
    wr_en = 1'b1; wr_addr = 3'd2; dat_in = 8'h55; rd_a = 3'd2; rd_b = 3'd2;
    #1;
    total++;
    if (obsv() !== {70{1'b0}}) begin
      bad++; $display("FAIL reset_hold got=%h want=%h", obsv(), {70{1'b0}});
    end
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      rd_a = 3'(i); rd_b = 3'(7 - i);
      #1;
      total++;
      if (obsv() !== {70{1'b0}}) begin
        bad++; $display("FAIL reset_read addr=%0d got=%h want=%h", i, obsv(), {70{1'b0}});
      end
    end
  endtask

  task automatic test_write();
    idle();
    wr_en = 1'b1; wr_addr = 3'd3; dat_in = 8'hA5; tick();
    wr_addr = 3'd5; dat_in = 8'h3C; tick();
    idle(); rd_a = 3'd3; rd_b = 3'd5;
    #1;
    total++;
    if ({bi1.datA_out, bi1.datB_out, bi0.datA_out, bi0.datB_out, bi1.r0_out, bi1.r1_out}
        !== {8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h00, 8'h00}) begin
      bad++; $display("FAIL write_read got=%h%h%h%h r0=%h r1=%h want=a53ca53c r0=00 r1=00",
                      bi1.datA_out, bi1.datB_out, bi0.datA_out, bi0.datB_out, bi1.r0_out, bi1.r1_out);
    end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1'b1; wr_addr = 3'd2; dat_in = 8'h7F; rd_a = 3'd2; rd_b = 3'd2;
    #1;
    total++;
    if ({bi1.datA_out, bi1.datB_out, bi0.datA_out, bi0.datB_out} !== {8'h7F, 8'h7F, 8'h00, 8'h00}) begin
      bad++; $display("FAIL bypass_same_cycle got=%h%h%h%h want=7f7f0000",
                      bi1.datA_out, bi1.datB_out, bi0.datA_out, bi0.datB_out);
    end
    tick();
    wr_en = 1'b0;
    #1;
    total++;
    if ({bi1.datA_out, bi0.datA_out, bi0.datB_out} !== {8'h7F, 8'h7F, 8'h7F}) begin
      bad++; $display("FAIL bypass_next_cycle got=%h%h%h want=7f7f7f",
                      bi1.datA_out, bi0.datA_out, bi0.datB_out);
    end
  endtask

  task automatic test_flags();
    idle();
    flag_we = 1'b1; sc_i = 1'b1; ng_i = 1'b1; z_i = 1'b0;
    #1;
    total++;
    if (bi1.sc_out !== 1'b0) begin
      bad++; $display("FAIL flag_no_bypass got=%b want=0", bi1.sc_out);
    end
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({bi1.sc_out, bi1.ngtv_out, bi1.zero_out, bi0.sc_out, bi0.ngtv_out, bi0.zero_out} !== 6'b110110) begin
        bad++; $display("FAIL flag_hold idle=%0d got=%b%b%b want=110", i, bi1.sc_out, bi1.ngtv_out, bi1.zero_out);
      end
      if (i < 2) tick();
    end
    flag_we = 1'b1; flag_clr = 1'b1; sc_i = 1'b1; ng_i = 1'b1; z_i = 1'b1;
    tick();
    idle(); #1;
    total++;
    if ({bi1.sc_out, bi1.ngtv_out, bi1.zero_out} !== 3'b000) begin
      bad++; $display("FAIL flag_clr_priority got=%b%b%b want=000", bi1.sc_out, bi1.ngtv_out, bi1.zero_out);
    end
  endtask

  task automatic test_pack();
    idle();
    wr_en = 1'b1; wr_addr = 3'd0; dat_in = 8'h81; tick();
    wr_addr = 3'd1; dat_in = 8'h07; tick();
    idle(); flag_we = 1'b1; sc_i = 1'b1; tick();
    idle(); #1;
    total++;
    if ({bi1.r0_out, bi1.r1_out, bi1.sc_out} !== {8'h81, 8'h07, 1'b1}) begin
      bad++; $display("FAIL pack r0=%h r1=%h sc=%b want r0=81 r1=07 sc=1", bi1.r0_out, bi1.r1_out, bi1.sc_out);
    end
  endtask

  task automatic test_reset_override();
    idle();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); dat_in = 8'(8'h11 * (i + 1)); tick();
    end
    idle(); flag_we = 1'b1; sc_i = 1'b1; ng_i = 1'b0; z_i = 1'b1; tick();
    reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; dat_in = 8'hEE; flag_we = 1'b1; ng_i = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      rd_a = 3'(i); rd_b = 3'(i);
      #1;
      total++;
      if ({bi1.datA_out, bi0.datB_out, bi1.sc_out, bi1.ngtv_out, bi1.zero_out} !== 19'd0) begin
        bad++; $display("FAIL reset_override addr=%0d got=%h %h flags=%b%b%b want=00 00 000",
                        i, bi1.datA_out, bi0.datB_out, bi1.sc_out, bi1.ngtv_out, bi1.zero_out);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 49) == 0);
      wr_en    = $urandom_range(0, 1);
      wr_addr  = 3'($urandom_range(0, 7));
      dat_in   = 8'($urandom);
      rd_a     = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      rd_b     = ($urandom_range(0, 3) == 0) ? rd_a : 3'($urandom_range(0, 7));
      flag_we  = $urandom_range(0, 1);
      flag_clr = ($urandom_range(0, 7) == 0);
      sc_i     = $urandom_range(0, 1);
      ng_i     = $urandom_range(0, 1);
      z_i      = $urandom_range(0, 1);
      #1;
      total++;
      if (obsv() !== expv()) begin
        bad++; $display("FAIL random n=%0d got=%h want=%h", n, obsv(), expv());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    msc = 1'b0; mng = 1'b0; mz = 1'b0;
    idle(); rd_a = 3'd0; rd_b = 3'd0;
    @(negedge clk);
    test_reset();
    test_write();
    test_bypass();
    test_flags();
    test_pack();
    test_reset_override();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
